// File: rtl/nx_dot_accum_requant.sv
// Accumulates signed dot-product partials into one sum per frame, then rounds,
// right-shifts and saturates the sum to int8 and queues it in a small output FIFO.
module nx_dot_accum_requant #(
   parameter int DIN_W = 20,
   parameter int ACC_W = 32,
   parameter int SHIFT = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DIN_W-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_sat,
   output logic             ovf_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic signed [ACC_W:0] RND =
      (SHIFT == 0) ? '0 : ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));
   localparam logic signed [ACC_W:0] MAX8 = 127;
   localparam logic signed [ACC_W:0] MIN8 = -128;

   // Both ports transfer on a rising edge where valid && ready; a source holding
   // valid without ready keeps its payload stable until it is taken.
   logic                    accept;
   logic                    in_frame;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] din_ext;
   logic signed [ACC_W-1:0] sum;
   logic                    ovf_hit;

   logic                    s1_valid;
   logic signed [ACC_W-1:0] s1_sum;
   logic signed [ACC_W:0]   rnd_sum;
   logic signed [ACC_W:0]   shifted;
   logic [7:0]              sat_data;
   logic                    sat_flag;
   logic                    s2_valid;
   logic [7:0]              s2_data;
   logic                    s2_sat;

   logic [8:0]              mem [DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [AW:0]             count;
   logic [AW+1:0]           occ;
   logic                    push;
   logic                    pop;

   assign accept  = in_valid && in_ready;
   assign din_ext = ACC_W'($signed(in_data));
   assign sum     = in_frame ? acc + din_ext : din_ext;
   assign ovf_hit = in_frame && (acc[ACC_W-1] == din_ext[ACC_W-1])
                    && (sum[ACC_W-1] != acc[ACC_W-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         in_frame <= 1'b0;
         ovf_err  <= 1'b0;
         s1_valid <= 1'b0;
         s1_sum   <= '0;
      end else begin
         s1_valid <= accept && in_last;
         if (accept) begin
            acc      <= sum;
            in_frame <= !in_last;
            if (in_last) s1_sum <= sum;
            if (ovf_hit) ovf_err <= 1'b1;
         end
      end
   end

   // One guard bit keeps the rounding addend from wrapping near full scale.
   always_comb begin
      rnd_sum  = {s1_sum[ACC_W-1], s1_sum} + RND;
      shifted  = rnd_sum >>> SHIFT;
      sat_data = shifted[7:0];
      sat_flag = 1'b0;
      if (shifted > MAX8) begin
         sat_data = 8'h7f;
         sat_flag = 1'b1;
      end else if (shifted < MIN8) begin
         sat_data = 8'h80;
         sat_flag = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_sat   <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= sat_data;
            s2_sat  <= sat_flag;
         end
      end
   end

   // Counting in-flight pipeline results as occupied guarantees a FIFO slot for each.
   assign occ       = (AW+2)'(count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
   assign in_ready  = occ < (AW+2)'(DEPTH);
   assign push      = s2_valid;
   assign out_valid = count != '0;
   assign pop       = out_valid && out_ready;
   assign out_data  = mem[rd_ptr][8:1];
   assign out_sat   = mem[rd_ptr][0];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {s2_data, s2_sat};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_nx_dot_accum_requant.sv
// Directed bench for nx_dot_accum_requant: default instance plus a 32-bit-input
// instance used for the accumulator overflow scenario.
module tb_nx_dot_accum_requant;

   localparam int DIN_W = 20;
   localparam int ACC_W = 32;
   localparam int SHIFT = 4;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [DIN_W-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [7:0]       out_data;
   logic             out_sat;
   logic             ovf_err;

   logic             rst_w = 1'b1;
   logic             in_valid_w = 1'b0;
   logic             in_ready_w;
   logic [31:0]      in_data_w = '0;
   logic             in_last_w = 1'b0;
   logic             out_valid_w;
   logic [7:0]       out_data_w;
   logic             out_sat_w;
   logic             ovf_err_w;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   nx_dot_accum_requant #(.DIN_W(DIN_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .ovf_err(ovf_err)
   );

   nx_dot_accum_requant #(.DIN_W(32), .ACC_W(32), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut_w (
      .clk(clk), .rst(rst_w), .in_valid(in_valid_w), .in_ready(in_ready_w), .in_data(in_data_w),
      .in_last(in_last_w), .out_valid(out_valid_w), .out_ready(1'b1), .out_data(out_data_w),
      .out_sat(out_sat_w), .ovf_err(ovf_err_w)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [DIN_W-1:0] d, input logic l);
      int waited = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && waited < 50) begin
         step();
         waited++;
      end
      n_checks++;
      if (!in_ready) begin
         $display("FAIL send_beat_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
         n_errors++;
      end
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rst_w = 1'b1;
      step();
      step();
      n_checks++;
      if ({out_valid, out_data, out_sat, ovf_err} !== 11'b0) begin
         $display("FAIL reset_outputs: valid/data/sat/ovf=%b, required all 0",
                  {out_valid, out_data, out_sat, ovf_err});
         n_errors++;
      end
      rst = 1'b0;
      rst_w = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
         n_errors++;
      end
   endtask

   task automatic test_frame();
      send_beat(100, 1'b0);
      send_beat(200, 1'b0);
      step();
      send_beat(-50, 1'b0);
      in_valid = 1'b1;
      in_data  = 30;
      in_last  = 1'b1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL frame_ready: got %b, required 1", in_ready);
         n_errors++;
      end
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL frame_latency_n: out_valid=%b, required 0", out_valid);
         n_errors++;
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL frame_latency_n1: out_valid=%b, required 0", out_valid);
         n_errors++;
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd18 || out_sat !== 1'b0) begin
         $display("FAIL frame_result: valid=%b data=%0d sat=%b, required 1 18 0",
                  out_valid, $signed(out_data), out_sat);
         n_errors++;
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         $display("FAIL frame_pop: out_valid=%b, required 0", out_valid);
         n_errors++;
      end
   endtask

   task automatic test_single_beats();
      int         din [6] = '{4000, -4000, -8, -9, 8, 7};
      logic [7:0] exp_d [6] = '{8'd127, 8'h80, 8'd0, 8'hff, 8'd1, 8'd0};
      logic       exp_s [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      bit         ok;
      for (int i = 0; i < 6; i++) begin
         send_beat(DIN_W'(din[i]), 1'b1);
         wait_out(ok);
         n_checks++;
         if (!ok || out_data !== exp_d[i] || out_sat !== exp_s[i]) begin
            $display("FAIL single_beat_%0d: in=%0d valid=%b data=%0d sat=%b, required data=%0d sat=%b",
                     i, din[i], out_valid, $signed(out_data), out_sat, $signed(exp_d[i]), exp_s[i]);
            n_errors++;
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      logic [DIN_W-1:0] vals [5] = '{16, 32, 48, 64, 80};
      logic [7:0] exp_q[$] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      logic [7:0] got_q[$];
      int  idx = 0;
      int  accepted = 0;
      bit  saw_ready = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_last   = 1'b1;
      in_data   = vals[0];
      for (int c = 0; c < 12; c++) begin
         if (in_valid && in_ready) begin
            accepted++;
            idx++;
         end
         step();
         if (idx < 5) in_data = vals[idx];
      end
      n_checks++;
      if (accepted !== 4 || in_ready !== 1'b0) begin
         $display("FAIL backpressure_full: accepted=%0d in_ready=%b, required 4 0", accepted, in_ready);
         n_errors++;
      end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd1 || out_sat !== 1'b0) begin
         $display("FAIL backpressure_hold: valid=%b data=%0d sat=%b, required 1 1 0",
                  out_valid, $signed(out_data), out_sat);
         n_errors++;
      end
      out_ready = 1'b1;
      for (int c = 0; c < 30 && got_q.size() < 5; c++) begin
         if (out_valid && out_ready) got_q.push_back(out_data);
         if (in_valid && in_ready) begin
            accepted++;
            idx++;
            saw_ready = 1'b1;
         end
         step();
         if (idx >= 5) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_checks++;
      if (accepted !== 5 || !saw_ready || got_q.size() !== 5) begin
         $display("FAIL backpressure_drain: accepted=%0d saw_ready=%b outputs=%0d, required 5 1 5",
                  accepted, saw_ready, got_q.size());
         n_errors++;
      end
      for (int i = 0; i < 5 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            $display("FAIL backpressure_order_%0d: got %0d, required %0d", i, got_q[i], exp_q[i]);
            n_errors++;
         end
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL backpressure_empty: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
         n_errors++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$] = '{8'd2, 8'd3};
      logic [7:0] got_q[$];
      out_ready = 1'b0;
      send_beat(16, 1'b0);
      step();
      step();
      send_beat(16, 1'b1);
      send_beat(48, 1'b1);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && got_q.size() < 2; c++) begin
         if (out_valid) got_q.push_back(out_data);
         step();
      end
      n_checks++;
      if (got_q.size() !== 2) begin
         $display("FAIL back_to_back_count: got %0d outputs, required 2", got_q.size());
         n_errors++;
      end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            $display("FAIL back_to_back_%0d: got %0d, required %0d", i, got_q[i], exp_q[i]);
            n_errors++;
         end
      end
   endtask

   task automatic test_overflow();
      in_valid_w = 1'b1;
      in_data_w  = 32'h7fff_fff5;
      in_last_w  = 1'b0;
      step();
      in_data_w  = 32'd20;
      in_last_w  = 1'b1;
      step();
      in_valid_w = 1'b0;
      in_last_w  = 1'b0;
      n_checks++;
      if (ovf_err_w !== 1'b1) begin
         $display("FAIL overflow_set: ovf_err=%b, required 1", ovf_err_w);
         n_errors++;
      end
      for (int i = 0; i < 5; i++) step();
      n_checks++;
      if (ovf_err_w !== 1'b1) begin
         $display("FAIL overflow_sticky: ovf_err=%b, required 1", ovf_err_w);
         n_errors++;
      end
      n_checks++;
      if (ovf_err !== 1'b0) begin
         $display("FAIL overflow_default_dut: ovf_err=%b, required 0", ovf_err);
         n_errors++;
      end
      rst_w = 1'b1;
      step();
      rst_w = 1'b0;
      n_checks++;
      if (ovf_err_w !== 1'b0) begin
         $display("FAIL overflow_clear: ovf_err=%b, required 0", ovf_err_w);
         n_errors++;
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      send_beat(1000, 1'b0);
      send_beat(1000, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || ovf_err !== 1'b0) begin
         $display("FAIL mid_reset_state: in_ready=%b out_valid=%b ovf_err=%b, required 1 0 0",
                  in_ready, out_valid, ovf_err);
         n_errors++;
      end
      send_beat(5, 1'b1);
      wait_out(ok);
      n_checks++;
      if (!ok || out_data !== 8'd0 || out_sat !== 1'b0 || ovf_err !== 1'b0) begin
         $display("FAIL mid_reset_result: valid=%b data=%0d sat=%b ovf=%b, required 1 0 0 0",
                  out_valid, $signed(out_data), out_sat, ovf_err);
         n_errors++;
      end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      test_reset();
      test_frame();
      test_single_beats();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nx_dot_accum_requant.md
NX_DOT_ACCUM_REQUANT -- requirements
Module: nx_dot_accum_requant

Interface
REQ-001 Parameters SHALL be:
- DIN_W, 20, signed width of one dot-product result.
- ACC_W, 32, signed accumulator width; ACC_W >= DIN_W.
- SHIFT, 4, requantisation right-shift, 0..ACC_W-2.
- DEPTH, 4, output FIFO entries, power of two, >= 2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock; all logic on its rising edge.
- rst, in, 1, synchronous reset, active-high.
- in_valid, in, 1, in_data and in_last are valid.
- in_ready, out, 1, block accepts the current beat.
- in_data, in, DIN_W, signed dot-product partial result.
- in_last, in, 1, final partial of the current output element.
- out_valid, out, 1, out_data, out_sat are valid.
- out_ready, in, 1, consumer accepts the current output.
- out_data, out, 8, signed int8 result.
- out_sat, out, 1, out_data was clipped.
- ovf_err, out, 1, sticky accumulator signed-overflow flag.

Function
REQ-003 A beat SHALL be accepted when in_valid && in_ready are both high on a clk edge; a beat with in_valid high and in_ready low SHALL be ignored, and the source holds it.
REQ-004 The first accepted beat of a frame SHALL load acc with sign-extended in_data; each later beat SHALL load acc + sext(in_data), computed modulo 2^ACC_W.
REQ-005 The beat after an accepted in_last beat SHALL start a new frame; a single beat with in_last set SHALL form a complete one-beat frame.
REQ-006 On an accepted in_last beat, the final sum (including that beat) SHALL be captured into pipeline stage S1 on the same edge.
REQ-007 Stage S2 SHALL compute r = (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up); when SHIFT = 0, r = sum.
REQ-008 S2 SHALL saturate r to [-128, 127], setting out_sat = 1 exactly when clipping occurs, then push {out_data, out_sat} into the FIFO.
REQ-009 Latency SHALL be: in_last accepted at edge N gives out_valid high after edge N+2 when the FIFO was empty.
REQ-010 An output SHALL be popped when out_valid && out_ready; out_data and out_sat SHALL stay stable while out_valid is high and out_ready is low.
REQ-011 A simultaneous push and pop SHALL leave the FIFO count unchanged, including when the FIFO is full.
REQ-012 in_ready SHALL equal (fifo_count + S1_valid + S2_valid) < DEPTH, registered-free (combinational from state only), so the FIFO never overflows.
REQ-013 ovf_err SHALL be set when an accumulation's two operands share a sign and the result's sign differs, and SHALL stay set until reset.
REQ-014 in_valid low between beats of a frame SHALL NOT affect the accumulation.
REQ-015 out_valid SHALL equal fifo_count != 0.

Reset
REQ-016 While rst is high, the following SHALL all be 0 at the next edge: acc, frame state (first-beat pending), S1/S2 valid, FIFO pointers and count, out_valid, out_data, out_sat, ovf_err.
REQ-017 rst asserted mid-frame SHALL discard the partial sum; the first beat accepted after reset SHALL start a new frame.
REQ-018 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-019 The bench SHALL run these directed scenarios with default parameters, SHIFT=4:
- Frame 100, 200, -50, 30(last) -> out_data=18, out_sat=0, out_valid 2 cycles after last.
- Single beat 4000(last) -> out_data=127, out_sat=1; single beat -4000(last) -> -128, out_sat=1.
- Rounding: single beats -8 -> 0; -9 -> -1; 8 -> 1; 7 -> 0.
- out_ready held 0, five one-beat frames offered -> 4 accepted, in_ready=0 afterwards; out_ready=1 -> outputs drain in order, in_ready returns.
- Beats 2^31-1-10 then 20 (ACC_W=32, wide DIN_W test config) -> ovf_err=1, held until rst.
- rst pulsed after 2 beats of a frame, then 5(last) -> output 0 (round(5/16)), not including the pre-reset beats; ovf_err=0.
